elbeth_pipe_skid_reg: RTL and testbench

ELBETH_PIPE_SKID_REG -- requirements
Module: elbeth_pipe_skid_reg

---
 rtl/elbeth_pipe_skid_reg_pkg.sv | 16 +
 rtl/elbeth_pipe_skid_reg_if.sv | 16 +
 rtl/elbeth_pipe_slot.sv | 36 +++
 rtl/elbeth_pipe_skid_reg.sv | 123 ++++++++++++
 tb/tb_elbeth_pipe_skid_reg.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/elbeth_pipe_skid_reg_pkg.sv
// Shared definitions for the elbeth pipeline stage registers:
// state encodings and default field widths.
package elbeth_pipe_skid_reg_pkg;

  localparam int ELBETH_DATA_W = 96;
  localparam int ELBETH_CTRL_W = 24;
  localparam int ELBETH_CNT_W  = 16;

  typedef logic [1:0] elbeth_state_t;

  // Encoding doubles as the occupancy count.
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_HALF  = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

endpackage

// File: rtl/elbeth_pipe_skid_reg_if.sv
// Stream handshake bundle: payload, control bits, valid/ready.
// A beat transfers on a rising edge where valid and ready are both 1; a master
// holding valid=1 keeps data/ctrl stable until that beat, and ready never
// depends combinationally on valid.
interface elbeth_pipe_skid_reg_if #(
  parameter int DATA_W = 96,
  parameter int CTRL_W = 24
);
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;
  logic [CTRL_W-1:0] ctrl;

  modport master (output valid, output data, output ctrl, input  ready);
  modport slave  (input  valid, input  data, input  ctrl, output ready);
endinterface

// File: rtl/elbeth_pipe_slot.sv
// One pipeline storage slot: payload + control register with load and a
// control-only clear (payload survives a kill so debug can still see it).
module elbeth_pipe_slot #(
  parameter int DATA_W = 96,
  parameter int CTRL_W = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              clr,
  input  logic [DATA_W-1:0] d_data,
  input  logic [CTRL_W-1:0] d_ctrl,
  output logic [DATA_W-1:0] q_data,
  output logic [CTRL_W-1:0] q_ctrl
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_data <= '0;
    end else if (load) begin
      q_data <= d_data;
    end
  end

  // Clear wins over load so a killed entry never leaves live control bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_ctrl <= '0;
    end else if (clr) begin
      q_ctrl <= '0;
    end else if (load) begin
      q_ctrl <= d_ctrl;
    end
  end

endmodule

// File: rtl/elbeth_pipe_skid_reg.sv
// Two-entry skid pipeline register: fully registered in_ready, 1-cycle latency,
// full throughput, flush kills held entries, saturating stall counter.
module elbeth_pipe_skid_reg
  import elbeth_pipe_skid_reg_pkg::*;
#(
  parameter int DATA_W = ELBETH_DATA_W,
  parameter int CTRL_W = ELBETH_CTRL_W,
  parameter int CNT_W  = ELBETH_CNT_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  elbeth_pipe_skid_reg_if.slave  up,
  elbeth_pipe_skid_reg_if.master dn,
  output logic [1:0]             occupancy,
  output logic [CNT_W-1:0]       stall_cnt
);

  elbeth_state_t     state_q, state_d;
  logic              in_ready_q;
  logic              out_valid_q;
  logic [CNT_W-1:0]  stall_q;
  logic              in_fire, out_fire;
  logic              main_load, skid_load, main_from_skid;
  logic [DATA_W-1:0] main_data, skid_data, main_d_data;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl, main_d_ctrl;

  assign in_fire  = up.valid & in_ready_q;
  assign out_fire = out_valid_q & dn.ready;

  always_comb begin
    state_d        = state_q;
    main_load      = 1'b0;
    skid_load      = 1'b0;
    main_from_skid = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (in_fire) begin
          main_load = 1'b1;
          state_d   = ST_HALF;
        end
      end
      ST_HALF: begin
        if (in_fire && out_fire) begin
          main_load = 1'b1;
        end else if (in_fire) begin
          skid_load = 1'b1;
          state_d   = ST_FULL;
        end else if (out_fire) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (out_fire) begin
          main_load      = 1'b1;
          main_from_skid = 1'b1;
          state_d        = ST_HALF;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    // A flush drops everything, including a beat accepted this very cycle.
    if (flush) begin
      state_d   = ST_EMPTY;
      main_load = 1'b0;
      skid_load = 1'b0;
    end
  end

  assign main_d_data = main_from_skid ? skid_data : up.data;
  assign main_d_ctrl = main_from_skid ? skid_ctrl : up.ctrl;

  elbeth_pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_main (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (main_load),
    .clr    (flush),
    .d_data (main_d_data),
    .d_ctrl (main_d_ctrl),
    .q_data (main_data),
    .q_ctrl (main_ctrl)
  );

  elbeth_pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_skid (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (skid_load),
    .clr    (flush),
    .d_data (up.data),
    .d_ctrl (up.ctrl),
    .q_data (skid_data),
    .q_ctrl (skid_ctrl)
  );

  // Handshake outputs are precomputed from next state so they come straight off flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= (state_d != ST_FULL);
      out_valid_q <= (state_d != ST_EMPTY);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else if (out_valid_q && !dn.ready && (stall_q != {CNT_W{1'b1}})) begin
      stall_q <= stall_q + 1'b1;
    end
  end

  assign up.ready  = in_ready_q;
  assign dn.valid  = out_valid_q;
  assign dn.data   = main_data;
  assign dn.ctrl   = out_valid_q ? main_ctrl : '0;
  assign occupancy = state_q;
  assign stall_cnt = stall_q;

endmodule

// File: tb/tb_elbeth_pipe_skid_reg.sv
// Directed bench for elbeth_pipe_skid_reg: scoreboard of accepted beats checked
// against emitted beats, plus hand-computed checks of state, flush, reset, stall.
module tb_elbeth_pipe_skid_reg;

  localparam int DW = 96;
  localparam int CW = 24;
  localparam int SW = DW + CW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic [1:0]  occupancy;
  logic [15:0] stall_cnt;
  logic [1:0]  s_occupancy;
  logic [3:0]  s_stall_cnt;

  int n_cmp = 0;
  int n_err = 0;
  logic [SW-1:0] exp_q[$];

  always #5 clk = ~clk;

  elbeth_pipe_skid_reg_if #(.DATA_W(DW), .CTRL_W(CW)) up_if ();
  elbeth_pipe_skid_reg_if #(.DATA_W(DW), .CTRL_W(CW)) dn_if ();
  elbeth_pipe_skid_reg_if #(.DATA_W(8), .CTRL_W(4)) s_up_if ();
  elbeth_pipe_skid_reg_if #(.DATA_W(8), .CTRL_W(4)) s_dn_if ();

  elbeth_pipe_skid_reg #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .up        (up_if),
    .dn        (dn_if),
    .occupancy (occupancy),
    .stall_cnt (stall_cnt)
  );

  elbeth_pipe_skid_reg #(.DATA_W(8), .CTRL_W(4), .CNT_W(4)) dut_sat (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (1'b0),
    .up        (s_up_if),
    .dn        (s_dn_if),
    .occupancy (s_occupancy),
    .stall_cnt (s_stall_cnt)
  );

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [DW-1:0] d, input logic [CW-1:0] c);
    up_if.valid = v;
    up_if.data  = d;
    up_if.ctrl  = c;
  endtask

  // Monitor: outputs first (pop), then inputs (push); flush/reset empty the model.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      chk("occ_legal", {127'd0, occupancy == 2'd3}, 128'd0);
      if (!dn_if.valid) chk("bubble_ctrl", {104'd0, dn_if.ctrl}, 128'd0);
      if (dn_if.valid && dn_if.ready && !flush) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", {8'd0, dn_if.ctrl, dn_if.data}, 128'd0);
        end else begin
          chk("beat", {8'd0, dn_if.ctrl, dn_if.data}, {8'd0, exp_q.pop_front()});
        end
      end
      if (flush) exp_q.delete();
      else if (up_if.valid && up_if.ready) exp_q.push_back({up_if.ctrl, up_if.data});
    end
  end

  initial begin
    drive(1'b0, '0, '0);
    dn_if.ready   = 1'b0;
    s_up_if.valid = 1'b0;
    s_up_if.data  = '0;
    s_up_if.ctrl  = '0;
    s_dn_if.ready = 1'b0;

    // Reset values
    repeat (2) tick();
    chk("rst_out_valid", {127'd0, dn_if.valid}, 128'd0);
    chk("rst_in_ready",  {127'd0, up_if.ready}, 128'd1);
    chk("rst_out_data",  {32'd0, dn_if.data}, 128'd0);
    chk("rst_out_ctrl",  {104'd0, dn_if.ctrl}, 128'd0);
    chk("rst_occ",       {126'd0, occupancy}, 128'd0);
    chk("rst_stall",     {112'd0, stall_cnt}, 128'd0);
    rst_n = 1'b1;

    // Streaming 1..8 at full rate
    dn_if.ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, DW'(i), CW'(24'h100 + i));
      tick();
      chk("stream_data", {32'd0, dn_if.data}, 128'(i));
      chk("stream_occ",  {126'd0, occupancy}, 128'd1);
    end
    drive(1'b0, '0, '0);
    tick();
    chk("stream_drain_occ", {126'd0, occupancy}, 128'd0);
    chk("stream_stall",     {112'd0, stall_cnt}, 128'd0);

    // Backpressure: A, B fill, C held off for 2 cycles
    dn_if.ready = 1'b0;
    drive(1'b1, 96'hA, 24'hA0);
    tick();
    chk("bp_occ_a", {126'd0, occupancy}, 128'd1);
    drive(1'b1, 96'hB, 24'hB0);
    tick();
    chk("bp_occ_full", {126'd0, occupancy}, 128'd2);
    chk("bp_in_ready", {127'd0, up_if.ready}, 128'd0);
    chk("bp_stall_1",  {112'd0, stall_cnt}, 128'd1);
    drive(1'b1, 96'hC, 24'hC0);
    tick();
    chk("bp_hold_data", {32'd0, dn_if.data}, 128'hA);
    tick();
    dn_if.ready = 1'b1;
    tick();
    chk("bp_b_data",   {32'd0, dn_if.data}, 128'hB);
    chk("bp_b_occ",    {126'd0, occupancy}, 128'd1);
    chk("bp_in_ready2", {127'd0, up_if.ready}, 128'd1);
    tick();
    chk("bp_c_data", {32'd0, dn_if.data}, 128'hC);
    drive(1'b0, '0, '0);
    tick();
    chk("bp_drain_occ", {126'd0, occupancy}, 128'd0);
    chk("bp_stall_3",   {112'd0, stall_cnt}, 128'd3);

    // Simultaneous in/out fire in HALF
    dn_if.ready = 1'b0;
    drive(1'b1, 96'h1111, 24'h1);
    tick();
    dn_if.ready = 1'b1;
    drive(1'b1, 96'h2222, 24'h2);
    tick();
    chk("sim_occ",  {126'd0, occupancy}, 128'd1);
    chk("sim_data", {32'd0, dn_if.data}, 128'h2222);
    chk("sim_ctrl", {104'd0, dn_if.ctrl}, 128'h2);
    drive(1'b0, '0, '0);
    tick();
    chk("sim_stall", {112'd0, stall_cnt}, 128'd3);

    // Flush in FULL with all-ones control
    dn_if.ready = 1'b0;
    drive(1'b1, 96'hD1, 24'hFFFFFF);
    tick();
    drive(1'b1, 96'hD2, 24'hFFFFFF);
    tick();
    chk("fl_occ_full", {126'd0, occupancy}, 128'd2);
    chk("fl_ctrl_pre", {104'd0, dn_if.ctrl}, 128'hFFFFFF);
    flush = 1'b1;
    drive(1'b1, 96'hD3, 24'hFFFFFF);
    tick();
    chk("fl_out_valid", {127'd0, dn_if.valid}, 128'd0);
    chk("fl_out_ctrl",  {104'd0, dn_if.ctrl}, 128'd0);
    chk("fl_occ",       {126'd0, occupancy}, 128'd0);
    chk("fl_data_kept", {32'd0, dn_if.data}, 128'hD1);
    chk("fl_in_ready",  {127'd0, up_if.ready}, 128'd1);
    chk("fl_stall",     {112'd0, stall_cnt}, 128'd5);
    flush = 1'b0;
    drive(1'b0, '0, '0);
    dn_if.ready = 1'b1;
    tick();
    chk("fl_after_valid", {127'd0, dn_if.valid}, 128'd0);

    // Flush in HALF with a concurrent in_fire: the new beat is dropped
    dn_if.ready = 1'b0;
    drive(1'b1, 96'hE1, 24'h3);
    tick();
    flush = 1'b1;
    drive(1'b1, 96'hE2, 24'h3);
    tick();
    flush = 1'b0;
    drive(1'b0, '0, '0);
    dn_if.ready = 1'b1;
    tick();
    chk("flh_valid", {127'd0, dn_if.valid}, 128'd0);
    chk("flh_occ",   {126'd0, occupancy}, 128'd0);
    chk("flh_stall", {112'd0, stall_cnt}, 128'd6);
    drive(1'b1, 96'hF0F0, 24'h5A);
    tick();
    chk("flh_new_ctrl", {104'd0, dn_if.ctrl}, 128'h5A);
    chk("flh_new_data", {32'd0, dn_if.data}, 128'hF0F0);
    drive(1'b0, '0, '0);
    tick();

    // Async reset mid-cycle while FULL
    dn_if.ready = 1'b0;
    drive(1'b1, 96'h61, 24'h7);
    tick();
    drive(1'b1, 96'h62, 24'h7);
    tick();
    chk("ar_occ_full", {126'd0, occupancy}, 128'd2);
    chk("ar_stall_pre", {112'd0, stall_cnt}, 128'd7);
    drive(1'b0, '0, '0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_out_valid", {127'd0, dn_if.valid}, 128'd0);
    chk("ar_in_ready",  {127'd0, up_if.ready}, 128'd1);
    chk("ar_occ",       {126'd0, occupancy}, 128'd0);
    chk("ar_stall",     {112'd0, stall_cnt}, 128'd0);
    chk("ar_data",      {32'd0, dn_if.data}, 128'd0);
    chk("ar_ctrl",      {104'd0, dn_if.ctrl}, 128'd0);
    tick();
    rst_n = 1'b1;
    dn_if.ready = 1'b1;
    drive(1'b1, 96'h4848, 24'h4);
    tick();
    chk("ar_first_data", {32'd0, dn_if.data}, 128'h4848);
    chk("ar_first_occ",  {126'd0, occupancy}, 128'd1);
    drive(1'b0, '0, '0);
    tick();
    chk("ar_drain_occ", {126'd0, occupancy}, 128'd0);

    // Stall counter saturation on the CNT_W=4 instance
    s_up_if.valid = 1'b1;
    s_up_if.data  = 8'h5;
    s_up_if.ctrl  = 4'h3;
    tick();
    s_up_if.valid = 1'b0;
    chk("sat_occ",     {126'd0, s_occupancy}, 128'd1);
    chk("sat_start",   {124'd0, s_stall_cnt}, 128'd0);
    repeat (10) tick();
    chk("sat_mid",     {124'd0, s_stall_cnt}, 128'd10);
    repeat (10) tick();
    chk("sat_cap",     {124'd0, s_stall_cnt}, 128'd15);
    chk("sat_ctrl",    {124'd0, s_dn_if.ctrl}, 128'h3);
    s_dn_if.ready = 1'b1;
    tick();
    chk("sat_drain",   {126'd0, s_occupancy}, 128'd0);
    chk("sat_hold",    {124'd0, s_stall_cnt}, 128'd15);

    tick();
    chk("queue_empty", 128'(exp_q.size()), 128'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
